// File: rtl/call_door_panel_if.sv
// Bus between the call/door panel and the floor controller (or its stand-in).
interface call_door_panel_if;
  logic [9:0] btn_raw;
  logic       open_btn;
  logic       close_btn;
  logic       door_sensor;
  logic       door;
  logic [9:0] reset_buttons;
  logic [9:0] requests;
  logic       open_door;
  logic       close_door;
  logic       dwell_active;

  modport master (
    output btn_raw, open_btn, close_btn, door_sensor, door, reset_buttons,
    input  requests, open_door, close_door, dwell_active
  );

  modport slave (
    input  btn_raw, open_btn, close_btn, door_sensor, door, reset_buttons,
    output requests, open_door, close_door, dwell_active
  );
endinterface

// File: rtl/call_door_panel.sv
// Call-button debounce/latch and door dwell timer feeding the elevator floor controller.
module call_door_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DWELL_CYCLES    = 200_000_000,
  parameter int unsigned CNT_W           = 28
) (
  input  logic               clk,
  input  logic               reset,
  call_door_panel_if.slave   bus
);

  localparam int unsigned N_BTN = 10;
  localparam int unsigned N_IN  = 13;
  localparam int unsigned B_OPN = 10;
  localparam int unsigned B_CLS = 11;
  localparam int unsigned B_SNS = 12;
  localparam logic [CNT_W-1:0] PRE_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_CLOSED, S_DWELL, S_CLOSING} state_t;

  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  w_agree;
  logic             w_tick;
  logic             w_close_rise;
  logic [N_IN-1:0]  r_sync1, r_sync2, r_samp, r_db;
  logic [N_BTN-1:0] r_db_prev;
  logic             r_close_prev;
  logic [CNT_W-1:0] r_pre;
  logic [N_BTN-1:0] r_requests;
  logic             r_open_door;
  logic             r_close_door;
  logic             r_dwell_active;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  assign w_raw        = {bus.door_sensor, bus.close_btn, bus.open_btn, bus.btn_raw};
  assign w_tick       = (r_pre == PRE_MAX);
  assign w_agree      = ~(r_samp ^ r_sync2);
  assign w_close_rise = r_db[B_CLS] & ~r_close_prev;

  // Synchronize, sample on tick, accept a level only when two consecutive ticks agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre        <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_samp       <= '0;
      r_db         <= '0;
      r_db_prev    <= '0;
      r_close_prev <= 1'b0;
    end else begin
      r_pre        <= w_tick ? '0 : r_pre + CNT_W'(1);
      r_sync1      <= w_raw;
      r_sync2      <= r_sync1;
      r_db_prev    <= r_db[N_BTN-1:0];
      r_close_prev <= r_db[B_CLS];
      if (w_tick) begin
        r_samp <= r_sync2;
        r_db   <= (r_db & ~w_agree) | (r_samp & w_agree);
      end
    end
  end

  // Pending calls: set on a debounced rising edge, clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_requests  <= '0;
      r_open_door <= 1'b0;
    end else begin
      r_requests  <= (r_requests | (r_db[N_BTN-1:0] & ~r_db_prev)) & ~bus.reset_buttons;
      r_open_door <= r_db[B_OPN] | r_db[B_SNS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_CLOSED;
      r_cnt          <= '0;
      r_close_door   <= 1'b0;
      r_dwell_active <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_next;
      r_close_door   <= (w_next == S_CLOSING);
      r_dwell_active <= (w_next == S_DWELL);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_CLOSED: begin
        if (bus.door) begin
          w_next     = S_DWELL;
          w_cnt_next = DWELL_MAX;
        end
      end
      S_DWELL: begin
        w_cnt_next = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        if (!bus.door) begin
          w_next = S_CLOSED;
        end else if (r_open_door) begin
          w_cnt_next = DWELL_MAX;
        end else if (w_close_rise || (r_cnt == '0)) begin
          w_next = S_CLOSING;
        end
      end
      S_CLOSING: begin
        if (!bus.door) begin
          w_next = S_CLOSED;
        end else if (r_open_door) begin
          w_next     = S_DWELL;
          w_cnt_next = DWELL_MAX;
        end
      end
      default: w_next = S_CLOSED;
    endcase
  end

  assign bus.requests     = r_requests;
  assign bus.open_door    = r_open_door;
  assign bus.close_door   = r_close_door;
  assign bus.dwell_active = r_dwell_active;

endmodule

// File: tb/tb_call_door_panel.sv
// Directed bench: fast-debounce instance for latch/door timing, slow one for glitch rejection.
module tb_call_door_panel;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  call_door_panel_if ifa ();
  call_door_panel_if ifb ();

  call_door_panel #(.DEBOUNCE_CYCLES(1), .DWELL_CYCLES(10), .CNT_W(28)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  call_door_panel #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(10), .CNT_W(28)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ifa.btn_raw = '0; ifa.open_btn = 0; ifa.close_btn = 0; ifa.door_sensor = 0;
    ifa.door = 0; ifa.reset_buttons = '0;
    ifb.btn_raw = '0; ifb.open_btn = 0; ifb.close_btn = 0; ifb.door_sensor = 0;
    ifb.door = 0; ifb.reset_buttons = '0;
    reset = 1'b1;
    step(3);
    check("rst_req_a",   32'(ifa.requests), 32'h0);
    check("rst_open_a",  32'(ifa.open_door), 32'h0);
    check("rst_close_a", 32'(ifa.close_door), 32'h0);
    check("rst_dwell_a", 32'(ifa.dwell_active), 32'h0);
    check("rst_req_b",   32'(ifb.requests), 32'h0);
    reset = 1'b0;
    step(1);

    // Glitch rejection with a tick every 4 clocks
    ifb.btn_raw = 10'h080; step(3);
    ifb.btn_raw = 10'h000; step(12);
    check("glitch_short", 32'(ifb.requests), 32'h0);
    ifb.btn_raw = 10'h080; step(12);
    ifb.btn_raw = 10'h000; step(12);
    check("glitch_long", 32'(ifb.requests), 32'h080);

    // G3 press, clear while held
    ifa.btn_raw = 10'h002; step(1);
    step(3);
    check("g3_n3", 32'(ifa.requests), 32'h0);
    step(1);
    check("g3_n4", 32'(ifa.requests), 32'h002);
    step(1);
    ifa.reset_buttons = 10'h002; step(1);
    check("g3_clear", 32'(ifa.requests), 32'h0);
    ifa.reset_buttons = 10'h000; step(1);
    check("g3_held1", 32'(ifa.requests), 32'h0);
    step(2);
    check("g3_held3", 32'(ifa.requests), 32'h0);
    ifa.btn_raw = 10'h000; step(6);

    // Clear coincides with a fresh C1U debounced edge
    ifa.btn_raw = 10'h200; step(1);
    step(3);
    ifa.reset_buttons = 10'h200; step(1);
    check("simul_n4", 32'(ifa.requests), 32'h0);
    ifa.reset_buttons = 10'h000; step(1);
    check("simul_n5", 32'(ifa.requests), 32'h0);
    step(2);
    check("simul_n7", 32'(ifa.requests), 32'h0);
    ifa.btn_raw = 10'h000; step(6);

    // Open button latency
    ifa.open_btn = 1'b1; step(4);
    check("open_n3", 32'(ifa.open_door), 32'h0);
    step(1);
    check("open_n4", 32'(ifa.open_door), 32'h1);
    ifa.open_btn = 1'b0; step(6);
    check("open_rel", 32'(ifa.open_door), 32'h0);

    // Plain dwell; door changes at edge M (now)
    ifa.door = 1'b1;
    check("dw_m0", 32'(ifa.dwell_active), 32'h0);
    step(1);
    check("dw_m1", 32'(ifa.dwell_active), 32'h1);
    for (int k = 2; k <= 10; k++) begin
      step(1);
      check($sformatf("dw_m%0d_close", k), 32'(ifa.close_door), 32'h0);
    end
    step(1);
    check("dw_m11_close", 32'(ifa.close_door), 32'h1);
    check("dw_m11_dwell", 32'(ifa.dwell_active), 32'h0);
    step(1);
    check("dw_m12_close", 32'(ifa.close_door), 32'h1);
    ifa.door = 1'b0; step(1);
    check("dw_m13_close", 32'(ifa.close_door), 32'h0);
    check("dw_m13_dwell", 32'(ifa.dwell_active), 32'h0);
    step(2);

    // Obstruction mid-dwell reloads; obstruction in CLOSING returns to DWELL
    ifa.door = 1'b1; step(3);
    ifa.door_sensor = 1'b1; step(5);
    check("obs_open_hi", 32'(ifa.open_door), 32'h1);
    ifa.door_sensor = 1'b0; step(5);
    check("obs_open_lo", 32'(ifa.open_door), 32'h0);
    check("obs_s9_dwell", 32'(ifa.dwell_active), 32'h1);
    step(9);
    check("obs_s18_close", 32'(ifa.close_door), 32'h0);
    step(1);
    check("obs_s19_close", 32'(ifa.close_door), 32'h1);
    ifa.door_sensor = 1'b1; step(5);
    check("obs_both_open", 32'(ifa.open_door), 32'h1);
    check("obs_both_close", 32'(ifa.close_door), 32'h1);
    step(1);
    check("obs_redwell_close", 32'(ifa.close_door), 32'h0);
    check("obs_redwell_dwell", 32'(ifa.dwell_active), 32'h1);
    ifa.door_sensor = 1'b0; ifa.door = 1'b0; step(1);
    check("obs_closed", 32'(ifa.dwell_active), 32'h0);
    step(8);
    check("obs_open_idle", 32'(ifa.open_door), 32'h0);

    // Close button 3 clocks into dwell
    ifa.door = 1'b1; step(1);
    check("cb_dwell", 32'(ifa.dwell_active), 32'h1);
    step(2);
    ifa.close_btn = 1'b1; step(4);
    check("cb_p3_close", 32'(ifa.close_door), 32'h0);
    step(1);
    check("cb_p4_close", 32'(ifa.close_door), 32'h1);
    ifa.close_btn = 1'b0; ifa.door = 1'b0; step(2);
    check("cb_closed_close", 32'(ifa.close_door), 32'h0);
    check("cb_closed_dwell", 32'(ifa.dwell_active), 32'h0);
    step(6);

    // Reset mid-dwell with a pending call
    ifa.door = 1'b1; ifa.btn_raw = 10'h004; step(6);
    check("rd_pre_dwell", 32'(ifa.dwell_active), 32'h1);
    check("rd_pre_req", 32'(ifa.requests), 32'h004);
    reset = 1'b1; ifa.door = 1'b0; ifa.btn_raw = 10'h000; step(1);
    check("rd_req",   32'(ifa.requests), 32'h0);
    check("rd_open",  32'(ifa.open_door), 32'h0);
    check("rd_close", 32'(ifa.close_door), 32'h0);
    check("rd_dwell", 32'(ifa.dwell_active), 32'h0);
    reset = 1'b0; step(6);
    check("rd_post_req", 32'(ifa.requests), 32'h0);
    check("rd_post_dwell", 32'(ifa.dwell_active), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
